// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg
//   Shared constants and helpers for the SRAM-backed FIFO.
//   BUF_DEPTH       : number of entries in the registered output buffer
//   BUF_COUNT_WIDTH : width of the output buffer occupancy count
//   wrap_inc()      : pointer increment with explicit wrap at depth-1
//                     (depth need not be a power of two)
//   level_width()   : width of the optional occupancy port for a given depth
package sram_fifo_pkg;

  localparam int BUF_DEPTH       = 2;
  localparam int BUF_COUNT_WIDTH = $clog2(BUF_DEPTH + 1);

  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Capacity is DEPTH + BUF_DEPTH, so two extra bits always suffice.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/dual_port_sram.sv
// dual_port_sram
//   Simple dual-port synchronous SRAM, one write port and one read port.
//   Read data is registered (1-cycle latency). A read and a write to the
//   same address in the same cycle returns the newly written word.
//   Ports:
//     clk            : clock, rising edge
//     chip_select    : enables both ports
//     output_enable  : enables the read data register update
//     write_enable   : write write_data to write_address
//     write_address  : write port address
//     write_data     : write port data
//     read_address   : read port address
//     read_data      : registered read data
module dual_port_sram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  chip_select,
  input  logic                  output_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [WIDTH-1:0]      read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (chip_select && write_enable) begin
      mem[write_address] <= write_data;
    end
    if (chip_select && output_enable) begin
      // Same-address collision forwards the word being written.
      if (write_enable && (write_address == read_address)) begin
        read_data <= write_data;
      end else begin
        read_data <= mem[read_address];
      end
    end
  end

endmodule

// File: rtl/sram_fifo_out_buf.sv
// sram_fifo_out_buf
//   Two-entry registered FIFO that holds words returned by the SRAM and
//   presents the head word to the consumer.
//   Ports:
//     clk     : clock, rising edge
//     rst     : asynchronous active-high reset
//     wr_en   : capture wr_data this cycle (caller guarantees space)
//     wr_data : word to capture
//     rd_en   : drop the head word this cycle (caller guarantees non-empty)
//     rd_data : head word, zero when empty
//     count   : number of words held (0..2)
module sram_fifo_out_buf
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [BUF_COUNT_WIDTH-1:0] count
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             wr_sel;
  logic             rd_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        if (wr_sel) begin
          entry1 <= wr_data;
        end else begin
          entry0 <= wr_data;
        end
        wr_sel <= ~wr_sel;
      end
      if (rd_en) begin
        rd_sel <= ~rd_sel;
      end
      count <= count + BUF_COUNT_WIDTH'(wr_en) - BUF_COUNT_WIDTH'(rd_en);
    end
  end

  // Output is a mux of registers only; forced to zero when nothing is held.
  assign rd_data = (count != '0) ? (rd_sel ? entry1 : entry0) : '0;

endmodule

// File: rtl/sram_fifo.sv
// sram_fifo
//   Valid/ready FIFO built on a dual_port_sram plus a 2-entry registered
//   output buffer, sustaining one word per cycle despite SRAM read latency.
//   Total capacity is DEPTH + 2.
//   Optional feature: define SRAM_FIFO_LEVEL_EN to add the 'level' port
//   (registered total occupancy).
//   Ports:
//     clk       : clock, rising edge
//     rst       : asynchronous active-high reset
//     in_valid  : producer has a word
//     in_ready  : FIFO accepts a word this cycle
//     in_data   : word to write
//     out_valid : out_data holds the head word
//     out_ready : consumer takes the head word this cycle
//     out_data  : head word
//     level     : occupancy (only with SRAM_FIFO_LEVEL_EN)
module sram_fifo
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data
`ifdef SRAM_FIFO_LEVEL_EN
  ,output logic [level_width(DEPTH)-1:0] level
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam int                  CW          = BUF_COUNT_WIDTH + 1;

  logic [ADDR_WIDTH-1:0]      wr_ptr;
  logic [ADDR_WIDTH-1:0]      rd_ptr;
  logic [ADDR_WIDTH:0]        sram_count;
  logic                       inflight;
  logic [BUF_COUNT_WIDTH-1:0] buf_count;
  logic [CW-1:0]              buf_committed;
  logic                       push;
  logic                       pop;
  logic                       rd_issue;
  logic [WIDTH-1:0]           sram_rd_data;

  assign in_ready  = ~rst & (sram_count < DEPTH_COUNT);
  assign push      = in_valid & in_ready;
  assign out_valid = (buf_count != '0);
  assign pop       = out_valid & out_ready;

  // Buffer slots already spoken for once this cycle's pop is credited.
  // A read may only be issued if its word will have a slot next cycle.
  assign buf_committed = CW'(buf_count) + CW'(inflight) - CW'(pop);
  assign rd_issue      = (sram_count != '0) && (buf_committed < CW'(BUF_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sram_count <= '0;
      inflight   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ADDR_WIDTH'(wrap_inc(int'(wr_ptr), DEPTH));
      end
      if (rd_issue) begin
        rd_ptr <= ADDR_WIDTH'(wrap_inc(int'(rd_ptr), DEPTH));
      end
      sram_count <= sram_count + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(rd_issue);
      inflight   <= rd_issue;
    end
  end

`ifdef SRAM_FIFO_LEVEL_EN
  localparam int LEVEL_WIDTH = level_width(DEPTH);

  // Every word in SRAM, in flight or buffered enters via push and leaves
  // via pop, so a push/pop counter tracks their sum exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= level + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
    end
  end
`endif

  dual_port_sram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk           (clk),
    .chip_select   (~rst),
    .output_enable (~rst),
    .write_enable  (push),
    .write_address (wr_ptr),
    .write_data    (in_data),
    .read_address  (rd_ptr),
    .read_data     (sram_rd_data)
  );

  sram_fifo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (sram_rd_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_sram_fifo.sv
// tb_sram_fifo
//   Self-checking bench for sram_fifo: a DEPTH=16 instance driven by a
//   directed vector table and hand-written sequences, and a DEPTH=5
//   instance exercised with random traffic against a queue model.
//   Define SRAM_FIFO_LEVEL_EN to also check the level port.
module tb_sram_fifo;

  logic clk;
  logic rst;

  logic       in_valid16, in_ready16, out_valid16, out_ready16;
  logic [7:0] in_data16, out_data16;
  logic       in_valid5, in_ready5, out_valid5, out_ready5;
  logic [7:0] in_data5, out_data5;
`ifdef SRAM_FIFO_LEVEL_EN
  logic [5:0] level16;
  logic [4:0] level5;
`endif

  int n_checks;
  int n_fail;

  logic [7:0] q16[$];
  logic [7:0] q5[$];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic [7:0] exp_od;
  } vec_t;

  vec_t vecs[12];

  sram_fifo #(.WIDTH(8), .DEPTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_data   (in_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_data  (out_data16)
`ifdef SRAM_FIFO_LEVEL_EN
    ,.level    (level16)
`endif
  );

  sram_fifo #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .in_data   (in_data5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_data  (out_data5)
`ifdef SRAM_FIFO_LEVEL_EN
    ,.level    (level5)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    in_valid16  = 1'b0;
    in_data16   = 8'h00;
    out_ready16 = 1'b0;
    in_valid5   = 1'b0;
    in_data5    = 8'h00;
    out_ready5  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid16  = v.iv;
    in_data16   = v.d;
    out_ready16 = v.ordy;
  endtask

  // Assert reset over two edges, check the reset-state outputs, release it
  // just after a rising edge.
  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  32'(in_ready16),  0);
    checkOutput("rst_out_valid", 32'(out_valid16), 0);
    checkOutput("rst_out_data",  32'(out_data16),  0);
    checkOutput("rst_out_valid5", 32'(out_valid5), 0);
`ifdef SRAM_FIFO_LEVEL_EN
    checkOutput("rst_level", 32'(level16), 0);
`endif
    rst = 1'b0;
    q16.delete();
    q5.delete();
  endtask

  // One clock cycle on either instance with a scoreboard: a popped word
  // must match the oldest accepted word.
  task automatic sbCycle(input bit use5, input logic iv, input logic [7:0] d,
                         input logic ordy, output bit pushed, output bit popped);
    logic       ov, ir;
    logic [7:0] od, exp;
    if (use5) begin
      in_valid5 = iv; in_data5 = d; out_ready5 = ordy;
      in_valid16 = 1'b0; out_ready16 = 1'b0;
    end else begin
      in_valid16 = iv; in_data16 = d; out_ready16 = ordy;
      in_valid5 = 1'b0; out_ready5 = 1'b0;
    end
    #1;
    ov = use5 ? out_valid5 : out_valid16;
    ir = use5 ? in_ready5  : in_ready16;
    od = use5 ? out_data5  : out_data16;
    popped = ov & ordy;
    pushed = iv & ir;
    if (popped) begin
      if ((use5 ? q5.size() : q16.size()) == 0) begin
        checkOutput("spurious_pop", 32'(od), 32'hFFFF_FFFF);
      end else begin
        exp = use5 ? q5.pop_front() : q16.pop_front();
        checkOutput(use5 ? "pop_data5" : "pop_data16", 32'(od), 32'(exp));
      end
    end
    if (pushed) begin
      if (use5) q5.push_back(d);
      else      q16.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  // Fixed-length drain; everything must have emerged by the end.
  task automatic drain(input bit use5, input int budget);
    bit p, q;
    for (int c = 0; c < budget; c++) begin
      sbCycle(use5, 1'b0, 8'h00, 1'b1, p, q);
    end
    checkOutput(use5 ? "drain_left5" : "drain_left16",
                use5 ? q5.size() : q16.size(), 0);
    checkOutput(use5 ? "drain_valid5" : "drain_valid16",
                32'(use5 ? out_valid5 : out_valid16), 0);
  endtask

  initial begin
    bit   p, q;
    int   accepted;
    int   gaps;
    bit   started;
    int   overflow;
    int   got;
    logic [7:0] nxt;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idleInputs();

    //            iv   d      ordy ir   ov   od
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

    doReset();

    // Single word latency and a two-word back-to-back burst.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_in_ready", i),  32'(in_ready16),  32'(vecs[i].exp_ir));
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid16), 32'(vecs[i].exp_ov));
      checkOutput($sformatf("vec%0d_out_data", i),  32'(out_data16),  32'(vecs[i].exp_od));
      @(posedge clk);
      #1;
    end

    // Fill with the consumer stalled: capacity is DEPTH + 2.
    accepted = 0;
    for (int c = 0; c < 30; c++) begin
      sbCycle(1'b0, 1'b1, 8'(accepted), 1'b0, p, q);
      if (p) accepted++;
    end
    checkOutput("fill_accepted", accepted, 18);
    checkOutput("fill_in_ready", 32'(in_ready16), 0);
`ifdef SRAM_FIFO_LEVEL_EN
    checkOutput("fill_level", 32'(level16), 18);
`endif
    drain(1'b0, 40);

    // Continuous streaming: no bubbles once the first word appears.
    nxt = 8'h00;
    gaps = 0;
    started = 1'b0;
    for (int c = 0; c < 200; c++) begin
      sbCycle(1'b0, 1'b1, nxt, 1'b1, p, q);
      if (p) nxt++;
      if (started && !q) gaps++;
      if (q) started = 1'b1;
    end
    checkOutput("stream_started", 32'(started), 1);
    checkOutput("stream_gaps", gaps, 0);
    checkOutput("stream_accepted", 32'(nxt), 32'd200 % 256);
    drain(1'b0, 40);

    // Full FIFO with simultaneous push and pop.
    accepted = 0;
    for (int c = 0; c < 30; c++) begin
      sbCycle(1'b0, 1'b1, 8'(100 + accepted), 1'b0, p, q);
      if (p) accepted++;
    end
    checkOutput("full_accepted", accepted, 18);
    #1;
    checkOutput("full_in_ready_p0", 32'(in_ready16), 0);
    sbCycle(1'b0, 1'b1, 8'hC0, 1'b1, p, q);
    checkOutput("full_p0_pushed", 32'(p), 0);
    checkOutput("full_p0_popped", 32'(q), 1);
    checkOutput("full_in_ready_p1", 32'(in_ready16), 1);
    for (int c = 0; c < 20; c++) begin
      sbCycle(1'b0, 1'b1, 8'(8'hC1 + c), 1'b1, p, q);
    end
    drain(1'b0, 40);

    // DEPTH=5: capacity 7, then random traffic across pointer wraps.
    accepted = 0;
    for (int c = 0; c < 20; c++) begin
      sbCycle(1'b1, 1'b1, 8'(8'h50 + accepted), 1'b0, p, q);
      if (p) accepted++;
    end
    checkOutput("dut5_fill_accepted", accepted, 7);
    overflow = 0;
    for (int c = 0; c < 400; c++) begin
      sbCycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), p, q);
      if (q5.size() > 7) overflow++;
    end
    checkOutput("dut5_overflow", overflow, 0);
    drain(1'b1, 30);

    // Reset while a read is in flight and a word is buffered.
    doReset();
    sbCycle(1'b0, 1'b1, 8'h11, 1'b0, p, q);
    sbCycle(1'b0, 1'b1, 8'h22, 1'b0, p, q);
    sbCycle(1'b0, 1'b0, 8'h00, 1'b0, p, q);
    checkOutput("pre_rst_out_valid", 32'(out_valid16), 1);
`ifdef SRAM_FIFO_LEVEL_EN
    checkOutput("pre_rst_level", 32'(level16), 2);
`endif
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid16), 0);
    checkOutput("mid_rst_out_data",  32'(out_data16),  0);
    checkOutput("mid_rst_in_ready",  32'(in_ready16),  0);
`ifdef SRAM_FIFO_LEVEL_EN
    checkOutput("mid_rst_level", 32'(level16), 0);
`endif
    q16.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbCycle(1'b0, 1'b1, 8'h3C, 1'b1, p, q);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      sbCycle(1'b0, 1'b0, 8'h00, 1'b1, p, q);
      if (q) got++;
    end
    checkOutput("post_rst_words", got, 1);
    checkOutput("post_rst_left", q16.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
